// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
// Receive-side TMDS decoder for one HDMI channel in the pixel clock domain.
// Finds the 10-bit word boundary from blanking control tokens by stepping a
// bit offset through a two-word window. No external bitslip is needed.
// Decodes video bytes and {C1,C0} control, and flags data-enable.
//
// Optional build macro: TMDS_DEC_ERRCNT_EN adds o_err_count, a saturating
// count of LOCKED->SEARCH transitions.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_WINDOW  = 1024,
  parameter int UNLOCK_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  i_tmds_word,
  output logic [7:0]  o_data,
  output logic [1:0]  o_ctrl,
  output logic        o_de,
  output logic        o_locked,
  output logic [3:0]  o_slip_offset
`ifdef TMDS_DEC_ERRCNT_EN
  ,
  output logic [15:0] o_err_count
`endif
);

  localparam int MAX_A   = (LOCK_COUNT > SEARCH_WINDOW) ? LOCK_COUNT : SEARCH_WINDOW;
  localparam int MAX_CNT = (MAX_A > UNLOCK_TIMEOUT) ? MAX_A : UNLOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_WINDOW - 1);
  localparam logic [CNT_W-1:0] UNLOCK_AT   = CNT_W'(UNLOCK_TIMEOUT);

  // Control tokens as they appear on the aligned word (bit0 first on wire).
  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  // Words ignored after a slip while the new offset works through the pipe.
  localparam logic [1:0] FLUSH_WORDS = 2'd2;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Counter step that holds at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // 16-bit event counter step, holds at 16'hFFFF.
  function automatic logic [15:0] err_sat_inc(input logic [15:0] c);
    return (&c) ? c : c + 16'd1;
  endfunction

  // Undo the TMDS transition-minimising code: optional inversion flagged by
  // bit 9, then XOR (bit 8 set) or XNOR chain between neighbouring bits.
  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] d;
    logic [7:0] o;
    d    = w[9] ? ~w[7:0] : w[7:0];
    o    = '0;
    o[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return o;
  endfunction

  logic [9:0]       word_p0;     // newest deserialized word
  logic [9:0]       word_p1;     // previous word
  logic [19:0]      win;         // two-word window the offset selects from
  logic [9:0]       slice;
  logic [9:0]       aligned_p2;  // word on the current boundary guess

  state_t           state;
  state_t           state_n;
  logic [3:0]       offset;
  logic [3:0]       offset_n;
  logic [CNT_W-1:0] tok_cnt;
  logic [CNT_W-1:0] tok_cnt_n;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_cnt_n;
  logic [1:0]       flush_cnt;
  logic [1:0]       flush_cnt_n;

  logic             is_tok;
  logic [1:0]       tok_val;
  logic [7:0]       data_dec;

  // Older word sits in the low half, so offset 0 selects it unshifted and
  // larger offsets borrow the leading bits of the newer word.
  assign win   = {word_p0, word_p1};
  assign slice = 10'(win >> offset);

  // Stage p0/p1: two-word capture; stage p2: boundary-aligned word.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_p0    <= '0;
      word_p1    <= '0;
      aligned_p2 <= '0;
    end else begin
      word_p0    <= i_tmds_word;
      word_p1    <= word_p0;
      aligned_p2 <= slice;
    end
  end

  // Classify the aligned word as one of the four control tokens or data.
  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (aligned_p2)
      TOK_C00: tok_val = 2'b00;
      TOK_C01: tok_val = 2'b01;
      TOK_C10: tok_val = 2'b10;
      TOK_C11: tok_val = 2'b11;
      default: is_tok  = 1'b0;
    endcase
  end

  assign data_dec = tmds_decode(aligned_p2);

  // Alignment FSM state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      offset    <= '0;
      tok_cnt   <= '0;
      idle_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      offset    <= offset_n;
      tok_cnt   <= tok_cnt_n;
      idle_cnt  <= idle_cnt_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // Next-state logic: search for a run of tokens, slip when a window passes
  // with none, and drop lock after a long token drought.
  always_comb begin
    state_n     = state;
    offset_n    = offset;
    tok_cnt_n   = tok_cnt;
    idle_cnt_n  = idle_cnt;
    flush_cnt_n = flush_cnt;
    case (state)
      SEARCH: begin
        if (flush_cnt != 2'd0) begin
          // Words still carry the previous offset; do not count them.
          flush_cnt_n = flush_cnt - 2'd1;
        end else if (is_tok) begin
          // A token both advances the lock run and ends any idle stretch,
          // so a lock can never coincide with a slip.
          idle_cnt_n = '0;
          if (tok_cnt >= LOCK_LAST) begin
            state_n   = LOCKED;
            tok_cnt_n = '0;
          end else begin
            tok_cnt_n = cnt_sat_inc(tok_cnt);
          end
        end else begin
          tok_cnt_n = '0;
          if (idle_cnt >= SEARCH_LAST) begin
            offset_n    = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            idle_cnt_n  = '0;
            flush_cnt_n = FLUSH_WORDS;
          end else begin
            idle_cnt_n = cnt_sat_inc(idle_cnt);
          end
        end
      end
      LOCKED: begin
        if (idle_cnt >= UNLOCK_AT) begin
          // Keep the offset: the link most likely just stalled.
          state_n    = SEARCH;
          tok_cnt_n  = '0;
          idle_cnt_n = '0;
        end else if (is_tok) begin
          idle_cnt_n = '0;
        end else begin
          idle_cnt_n = cnt_sat_inc(idle_cnt);
        end
      end
      default: begin
        state_n = SEARCH;
      end
    endcase
  end

  // Stage p3: registered outputs, driven from the next state so o_locked
  // rises together with the first locked o_de/o_ctrl value.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_data   <= '0;
      o_ctrl   <= '0;
      o_de     <= 1'b0;
      o_locked <= 1'b0;
    end else if (state_n == LOCKED) begin
      o_locked <= 1'b1;
      if (is_tok) begin
        o_de   <= 1'b0;
        o_ctrl <= tok_val;
        o_data <= '0;
      end else begin
        o_de   <= 1'b1;
        o_data <= data_dec;
      end
    end else begin
      o_data   <= '0;
      o_ctrl   <= '0;
      o_de     <= 1'b0;
      o_locked <= 1'b0;
    end
  end

  assign o_slip_offset = offset;

`ifdef TMDS_DEC_ERRCNT_EN
  // Count every loss of lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_err_count <= '0;
    end else if (state == LOCKED && state_n == SEARCH) begin
      o_err_count <= err_sat_inc(o_err_count);
    end
  end
`endif

endmodule
